// File: rtl/trigger_prog_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_pkg
//  Description : Shared definitions for the trigger programming controller.
//                Holds the pattern-entry field layout, buffer depth and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_pkg;

  localparam int DEPTH    = 64;
  localparam int AW       = 6;
  localparam int EW       = 18;  // entry width

  // Entry layout: [17] line state, [16:8] high (max) count, [7:0] low (min) count
  localparam int LINE_BIT = 17;
  localparam int HIGH_MSB = 16;
  localparam int HIGH_LSB = 8;
  localparam int LOW_MSB  = 7;
  localparam int LOW_LSB  = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LD_SETUP  = 3'd1;
  localparam state_t ST_LD_WR     = 3'd2;
  localparam state_t ST_LD_GAP    = 3'd3;
  localparam state_t ST_LD_END    = 3'd4;
  localparam state_t ST_ARMED     = 3'd5;
  localparam state_t ST_TRIGGERED = 3'd6;

  // True while the engine RAM is being programmed.
  function automatic logic is_load_state(input state_t s);
    return (s == ST_LD_SETUP) || (s == ST_LD_WR) ||
           (s == ST_LD_GAP)   || (s == ST_LD_END);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_prog_ctrl_if
//  Description : Host configuration/command/status bus plus the trigger
//                engine programming and run-control signals.
//                master : host / engine side (drives cfg_*, cmd_*, trig_out)
//                slave  : trigger_prog_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
interface trigger_prog_ctrl_if #(
  parameter int AW = 6
);
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [17:0]   cfg_data;
  logic [AW:0]   cfg_len;
  logic [17:0]   cfg_clkdiv;
  logic          cfg_rearm;
  logic          cmd_load;
  logic          cmd_arm;
  logic          cmd_disarm;
  logic          busy;
  logic          armed;
  logic          programmed;
  logic          done;
  logic          err;
  logic [15:0]   trig_count;
  logic          state_prog_en;
  logic          state_prog_wr;
  logic [8:0]    state_prog_addr;
  logic [17:0]   state_prog_data;
  logic [17:0]   clkdivider;
  logic          trig_rst;
  logic          trig_out;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, cfg_len, cfg_clkdiv, cfg_rearm,
           cmd_load, cmd_arm, cmd_disarm, trig_out,
    input  busy, armed, programmed, done, err, trig_count, state_prog_en,
           state_prog_wr, state_prog_addr, state_prog_data, clkdivider, trig_rst
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, cfg_len, cfg_clkdiv, cfg_rearm,
           cmd_load, cmd_arm, cmd_disarm, trig_out,
    output busy, armed, programmed, done, err, trig_count, state_prog_en,
           state_prog_wr, state_prog_addr, state_prog_data, clkdivider, trig_rst
  );
endinterface
`default_nettype wire

// File: rtl/trigger_prog_ctrl_shadow_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_shadow_ram
//  Description : DEPTH x DW shadow pattern buffer, one write port and one
//                synchronous read port (1-cycle latency, read data holds
//                while re is low). Contents are not reset.
//  Ports       : clk; we/waddr/wdata write port; re/raddr/rdata read port
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_shadow_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/trigger_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_prog_ctrl
//  Description : Stages pattern entries in a shadow buffer, replays them into
//                the trigger engine state RAM with the state_prog_en/_wr
//                protocol, then arms the engine, counts trigger events and
//                optionally re-arms.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - trigger_prog_ctrl_if.slave (host cfg/cmd/status and
//                         engine programming/run-control signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_prog_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  trigger_prog_ctrl_if.slave  bus
);
  import trigger_pkg::*;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_len;
  logic          r_programmed;
  logic          r_err;
  logic          r_trig_prev;
  logic [15:0]   r_trig_count;
  logic [17:0]   r_clkdiv;
  logic [EW-1:0] w_rd_data;

  logic w_in_load;
  logic w_len_ok;
  logic w_load_ok;
  logic w_arm_ok;
  logic w_edge;
  logic w_last;
  logic w_count_en;
  logic w_err;

  assign w_in_load = is_load_state(r_state);
  assign w_len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= (AW+1)'(DEPTH));
  assign w_load_ok = (r_state == ST_IDLE) && bus.cmd_load && w_len_ok;
  // A simultaneous accepted load takes precedence over an arm request.
  assign w_arm_ok  = (r_state == ST_IDLE) && bus.cmd_arm && r_programmed && !w_load_ok;
  assign w_edge    = bus.trig_out && !r_trig_prev;
  assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
  // Disarm outranks a coincident trigger edge, so that edge is not counted.
  assign w_count_en = (r_state == ST_ARMED) && w_edge && !bus.cmd_disarm;
  assign w_err     = (bus.cmd_load && !w_load_ok) ||
                     (bus.cmd_arm  && !w_arm_ok)  ||
                     (bus.cfg_wr   && w_in_load);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_ok)     w_state_nxt = ST_LD_SETUP;
        else if (w_arm_ok) w_state_nxt = ST_ARMED;
      end
      ST_LD_SETUP:  w_state_nxt = ST_LD_WR;
      ST_LD_WR:     w_state_nxt = ST_LD_GAP;
      ST_LD_GAP:    w_state_nxt = w_last ? ST_LD_END : ST_LD_WR;
      ST_LD_END:    w_state_nxt = ST_IDLE;
      ST_ARMED: begin
        if (bus.cmd_disarm) w_state_nxt = ST_IDLE;
        else if (w_edge)    w_state_nxt = ST_TRIGGERED;
      end
      ST_TRIGGERED: begin
        if (bus.cmd_disarm)     w_state_nxt = ST_IDLE;
        else if (bus.cfg_rearm) w_state_nxt = ST_ARMED;
        else                    w_state_nxt = ST_IDLE;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_programmed <= 1'b0;
      r_err        <= 1'b0;
      r_trig_prev  <= 1'b0;
      r_trig_count <= '0;
      r_clkdiv     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_err       <= w_err;
      r_trig_prev <= bus.trig_out;
      if (w_load_ok) begin
        r_idx        <= '0;
        r_len        <= bus.cfg_len;
        r_programmed <= 1'b0;
        r_trig_count <= '0;
      end else begin
        if (r_state == ST_LD_GAP) r_idx <= r_idx + 1'b1;
        if (r_state == ST_LD_END) r_programmed <= 1'b1;
        if (w_count_en && (r_trig_count != 16'hFFFF))
          r_trig_count <= r_trig_count + 1'b1;
      end
      if (w_arm_ok) r_clkdiv <= bus.cfg_clkdiv;
    end
  end

  // Reads are issued in LD_SETUP (index 0) and LD_GAP (next index) so the
  // data is on the read port during the following LD_WR cycle.
  trigger_shadow_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (EW)
  ) u_shadow (
    .clk   (clk),
    .we    (bus.cfg_wr && !w_in_load),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .re    ((r_state == ST_LD_SETUP) || (r_state == ST_LD_GAP)),
    .raddr ((r_state == ST_LD_GAP) ? (r_idx + 1'b1) : r_idx),
    .rdata (w_rd_data)
  );

  assign bus.busy            = w_in_load;
  assign bus.state_prog_en   = w_in_load;
  assign bus.state_prog_wr   = (r_state == ST_LD_WR);
  assign bus.state_prog_addr = {{(9-AW){1'b0}}, r_idx};
  // Data is gated to the write cycle so the unreset RAM never shows on the bus.
  assign bus.state_prog_data = (r_state == ST_LD_WR) ? w_rd_data : '0;
  assign bus.armed           = (r_state == ST_ARMED) || (r_state == ST_TRIGGERED);
  assign bus.done            = (r_state == ST_TRIGGERED);
  assign bus.trig_rst        = (r_state != ST_ARMED);
  assign bus.programmed      = r_programmed;
  assign bus.err             = r_err;
  assign bus.trig_count      = r_trig_count;
  assign bus.clkdivider      = r_clkdiv;

endmodule
`default_nettype wire

// File: tb/tb_trigger_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_prog_ctrl
//  Description : Directed-plus-random bench for trigger_prog_ctrl with a
//                behavioural shadow/counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_prog_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [17:0] m_shadow [DEPTH];
  int          m_count;

  trigger_prog_ctrl_if #(.AW(AW)) bus ();

  trigger_prog_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ent(input bit line, input int hi, input int lo);
    logic [8:0] h;
    logic [7:0] l;
    h = 9'(hi);
    l = 8'(lo);
    return {line, h, l};
  endfunction

  task automatic shadow_wr(input int a, input logic [17:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = 6'(a); bus.cfg_data = d;
    cyc();
    bus.cfg_wr = 1'b0;
    m_shadow[a] = d;
    chk("wr_no_err", 32'(bus.err), 0);
  endtask

  // Runs a legal load of n entries; if bad_at >= 0, a shadow write to entry 2
  // is attempted at that busy cycle and must be dropped with an err pulse.
  task automatic run_load(input int n, input int bad_at);
    int busy_cyc, nwr;
    bit want_err;
    logic [17:0] exp;
    busy_cyc = 0; nwr = 0; want_err = 0;
    bus.cfg_len = 7'(n); bus.cmd_load = 1'b1;
    cyc();
    bus.cmd_load = 1'b0;
    m_count = 0;
    chk("ld_en_before_wr", {30'd0, bus.state_prog_en, bus.state_prog_wr}, 2'b10);
    chk("ld_prog_cleared", 32'(bus.programmed), 0);
    chk("ld_count_cleared", 32'(bus.trig_count), 0);
    while (bus.busy === 1'b1 && busy_cyc < 2*DEPTH+8) begin
      if (want_err) begin
        chk("ld_bad_wr_err", 32'(bus.err), 1);
        want_err = 0;
      end
      if (bus.state_prog_wr === 1'b1) begin
        exp = (nwr < DEPTH) ? m_shadow[nwr] : 18'h0;
        chk("wr_addr", 32'(bus.state_prog_addr), nwr);
        chk("wr_data", 32'(bus.state_prog_data), 32'(exp));
        nwr++;
      end
      bus.cfg_wr = 1'b0;
      if (busy_cyc == bad_at) begin
        bus.cfg_wr = 1'b1; bus.cfg_addr = 6'd2; bus.cfg_data = ~m_shadow[2];
        want_err = 1;
      end
      busy_cyc++;
      cyc();
    end
    bus.cfg_wr = 1'b0;
    chk("ld_busy_cycles", busy_cyc, 2*n+2);
    chk("ld_wr_count", nwr, n);
    chk("ld_programmed", 32'(bus.programmed), 1);
    chk("ld_en_dropped", 32'(bus.state_prog_en), 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_count = 0;
    rst_n = 1'b0;
    bus.cfg_wr = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_len = '0;
    bus.cfg_clkdiv = '0; bus.cfg_rearm = 0; bus.cmd_load = 0; bus.cmd_arm = 0;
    bus.cmd_disarm = 0; bus.trig_out = 0;
    repeat (3) cyc();

    // Reset state
    chk("rst_flags", {25'd0, bus.busy, bus.armed, bus.programmed, bus.done,
                      bus.err, bus.state_prog_en, bus.state_prog_wr}, 0);
    chk("rst_trig_rst", 32'(bus.trig_rst), 1);
    chk("rst_count", 32'(bus.trig_count), 0);
    chk("rst_clkdiv", 32'(bus.clkdivider), 0);
    chk("rst_prog_bus", {5'd0, bus.state_prog_addr, bus.state_prog_data}, 0);
    rst_n = 1'b1;
    cyc();

    // Arm before anything is programmed is illegal
    bus.cmd_arm = 1'b1; cyc(); bus.cmd_arm = 1'b0;
    chk("arm_unprog_err", 32'(bus.err), 1);
    chk("arm_unprog_armed", 32'(bus.armed), 0);

    // Basic load
    shadow_wr(0, ent(1, 20, 10));
    shadow_wr(1, ent(0, 9, 5));
    shadow_wr(2, ent(1, 4, 2));
    chk("ent0_const", 32'(m_shadow[0]), 32'h2140A);
    chk("ent2_const", 32'(m_shadow[2]), 32'h20402);
    run_load(3, -1);

    // Illegal loads: length 0 and 65
    for (int k = 0; k < 2; k++) begin
      bus.cfg_len = (k == 0) ? 7'd0 : 7'd65;
      bus.cmd_load = 1'b1; cyc(); bus.cmd_load = 0;
      chk("bad_len_err", 32'(bus.err), 1);
      chk("bad_len_idle", {30'd0, bus.busy, bus.state_prog_en}, 0);
      cyc();
      chk("bad_len_err_clr", 32'(bus.err), 0);
      chk("bad_len_prog_kept", 32'(bus.programmed), 1);
    end

    // Single trigger
    bus.cfg_clkdiv = 18'd695; bus.cfg_rearm = 0;
    bus.cmd_arm = 1'b1; cyc(); bus.cmd_arm = 0;
    chk("arm_armed", 32'(bus.armed), 1);
    chk("arm_trig_rst", 32'(bus.trig_rst), 0);
    chk("arm_clkdiv", 32'(bus.clkdivider), 695);
    repeat ($urandom_range(1, 4)) cyc();
    bus.trig_out = 1'b1; cyc(); m_count++;
    chk("trig1_done", 32'(bus.done), 1);
    chk("trig1_count", 32'(bus.trig_count), m_count);
    chk("trig1_rst", 32'(bus.trig_rst), 1);
    cyc();
    bus.trig_out = 1'b0;
    chk("trig1_done_pulse", 32'(bus.done), 0);
    chk("trig1_disarmed", 32'(bus.armed), 0);
    chk("trig1_rst_idle", 32'(bus.trig_rst), 1);

    // Random reload clears the counter
    for (int i = 0; i < 12; i++) shadow_wr(i, 18'($urandom));
    run_load($urandom_range(1, 12), -1);

    // Re-arm with three pulses, then disarm coincident with a fourth edge
    bus.cfg_rearm = 1'b1; bus.cfg_clkdiv = 18'($urandom);
    bus.cmd_arm = 1'b1; cyc(); bus.cmd_arm = 0;
    chk("rearm_clkdiv", 32'(bus.clkdivider), 32'(bus.cfg_clkdiv));
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(1, 5)) cyc();
      chk("rearm_running", {30'd0, bus.armed, bus.trig_rst}, 2'b10);
      bus.trig_out = 1'b1; cyc(); m_count++;
      chk("rearm_done", 32'(bus.done), 1);
      chk("rearm_count", 32'(bus.trig_count), m_count);
      bus.trig_out = 1'b0; cyc();
      chk("rearm_back", {29'd0, bus.armed, bus.trig_rst, bus.done}, 3'b100);
    end
    repeat (2) cyc();
    bus.trig_out = 1'b1; bus.cmd_disarm = 1'b1; cyc();
    bus.trig_out = 1'b0; bus.cmd_disarm = 1'b0;
    chk("disarm_state", {29'd0, bus.armed, bus.trig_rst, bus.done}, 3'b010);
    chk("disarm_count", 32'(bus.trig_count), 3);
    cyc();
    chk("disarm_no_done", 32'(bus.done), 0);
    chk("disarm_count_hold", 32'(bus.trig_count), 3);

    // Bad shadow write during a 10-entry load
    for (int i = 0; i < 10; i++) shadow_wr(i, 18'($urandom));
    run_load(10, $urandom_range(2, 12));

    // Asynchronous reset in the middle of a 10-entry load
    bus.cfg_len = 7'd10; bus.cmd_load = 1'b1; cyc(); bus.cmd_load = 0;
    begin
      int guard;
      guard = 0;
      repeat ($urandom_range(0, 4)) cyc();
      while (bus.state_prog_wr !== 1'b1 && guard < 10) begin
        guard++;
        cyc();
      end
      chk("mid_load_in_wr", 32'(bus.state_prog_wr), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {29'd0, bus.state_prog_en, bus.state_prog_wr, bus.busy}, 0);
    chk("arst_programmed", 32'(bus.programmed), 0);
    chk("arst_trig_rst", 32'(bus.trig_rst), 1);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("after_arst_idle", {29'd0, bus.state_prog_en, bus.programmed, bus.armed}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
